reorder_buffer: RTL and testbench

//  Circular in-order commit queue between issue/decode and RegisterFile.

---
 rtl/reorder_buffer.sv | 120 ++++++++++++
 tb/tb_reorder_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit queue that tags issued instructions,
// captures CDB results, retires one entry per cycle and flushes on a mispredicted branch.
module reorder_buffer #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_rd,
   input  logic                 issue_is_branch,
   input  logic                 issue_pred_taken,
   output logic                 rob_full,
   output logic [ROB_WIDTH-1:0] rob_alloc_index,
   input  logic                 cdb_valid,
   input  logic [ROB_WIDTH-1:0] cdb_rob_index,
   input  logic [31:0]          cdb_val,
   input  logic                 cdb_taken,
   input  logic [31:0]          cdb_target,
   input  logic [ROB_WIDTH-1:0] dc_rs1_depend,
   output logic                 rob_rs1_ready,
   output logic [31:0]          rob_rs1_val,
   input  logic [ROB_WIDTH-1:0] dc_rs2_depend,
   output logic                 rob_rs2_ready,
   output logic [31:0]          rob_rs2_val,
   output logic                 rob_to_reg_commit,
   output logic [ROB_WIDTH-1:0] rob_to_reg_rob_index,
   output logic [4:0]           rob_to_reg_index,
   output logic [31:0]          rob_to_reg_val,
   output logic                 clr_out,
   output logic [31:0]          clr_pc
);
   localparam int N = (1 << ROB_WIDTH) - 1;
   typedef logic [ROB_WIDTH-1:0] tag_t;

   logic [N:0]  busy, ready, is_br, pred, taken;
   logic [4:0]  rd     [N:0];
   logic [31:0] val    [N:0];
   logic [31:0] target [N:0];
   tag_t        head, tail, count;
   logic        do_issue, do_cdb, do_commit, mispred;
   logic        hit1, hit2;

   function automatic tag_t nxt(input tag_t t);
      return (t == tag_t'(N)) ? tag_t'(1) : t + tag_t'(1);
   endfunction

   assign rob_full        = count == tag_t'(N);
   assign rob_alloc_index = tail;

   // Requests arriving while the flush pulse is out belong to the squashed path.
   always_comb begin
      do_issue  = issue_valid && !rob_full && !clr_out;
      do_cdb    = cdb_valid && !clr_out && busy[cdb_rob_index];
      do_commit = busy[head] && ready[head];
      mispred   = is_br[head] && (taken[head] != pred[head]);
      hit1      = cdb_valid && (cdb_rob_index == dc_rs1_depend);
      hit2      = cdb_valid && (cdb_rob_index == dc_rs2_depend);
      rob_rs1_ready = (dc_rs1_depend != '0) && (hit1 || ready[dc_rs1_depend]);
      rob_rs2_ready = (dc_rs2_depend != '0) && (hit2 || ready[dc_rs2_depend]);
      rob_rs1_val   = !rob_rs1_ready ? 32'd0 : hit1 ? cdb_val : val[dc_rs1_depend];
      rob_rs2_val   = !rob_rs2_ready ? 32'd0 : hit2 ? cdb_val : val[dc_rs2_depend];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head                 <= tag_t'(1);
         tail                 <= tag_t'(1);
         count                <= '0;
         busy                 <= '0;
         ready                <= '0;
         rob_to_reg_commit    <= 1'b0;
         rob_to_reg_rob_index <= '0;
         rob_to_reg_index     <= '0;
         rob_to_reg_val       <= '0;
         clr_out              <= 1'b0;
         clr_pc               <= '0;
      end else if (!rdy_in) begin
         rob_to_reg_commit <= 1'b0;
         clr_out           <= 1'b0;
      end else begin
         rob_to_reg_commit <= do_commit;
         clr_out           <= do_commit && mispred;
         if (do_commit) begin
            rob_to_reg_rob_index <= head;
            rob_to_reg_index     <= is_br[head] ? 5'd0 : rd[head];
            rob_to_reg_val       <= is_br[head] ? 32'd0 : val[head];
            if (mispred)
               clr_pc <= target[head];
         end
         if (do_issue) begin
            busy[tail]   <= 1'b1;
            ready[tail]  <= 1'b0;
            rd[tail]     <= issue_rd;
            is_br[tail]  <= issue_is_branch;
            pred[tail]   <= issue_pred_taken;
            tail         <= nxt(tail);
         end
         if (do_cdb) begin
            ready[cdb_rob_index]  <= 1'b1;
            val[cdb_rob_index]    <= cdb_val;
            taken[cdb_rob_index]  <= cdb_taken;
            target[cdb_rob_index] <= cdb_target;
         end
         if (do_commit) begin
            busy[head]  <= 1'b0;
            ready[head] <= 1'b0;
            head        <= nxt(head);
         end
         count <= count + tag_t'(do_issue) - tag_t'(do_commit);
         if (do_commit && mispred) begin
            head  <= tag_t'(1);
            tail  <= tag_t'(1);
            count <= '0;
            busy  <= '0;
            ready <= '0;
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus with a commit scoreboard for reorder_buffer.
module tb_reorder_buffer;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1, rdy_in = 1'b1;
   logic        issue_valid = 1'b0, issue_is_branch = 1'b0, issue_pred_taken = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        rob_full;
   logic [3:0]  rob_alloc_index;
   logic        cdb_valid = 1'b0, cdb_taken = 1'b0;
   logic [3:0]  cdb_rob_index = '0;
   logic [31:0] cdb_val = '0, cdb_target = '0;
   logic [3:0]  dc_rs1_depend = '0, dc_rs2_depend = '0;
   logic        rob_rs1_ready, rob_rs2_ready;
   logic [31:0] rob_rs1_val, rob_rs2_val;
   logic        rob_to_reg_commit, clr_out;
   logic [3:0]  rob_to_reg_rob_index;
   logic [4:0]  rob_to_reg_index;
   logic [31:0] rob_to_reg_val, clr_pc;

   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  rd;
      logic [31:0] val;
      logic        clr;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   int   ccyc[$];
   int   cyc = 0, total = 0, bad = 0, mark = 0;

   reorder_buffer #(.ROB_WIDTH(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
      .issue_pred_taken(issue_pred_taken), .rob_full(rob_full), .rob_alloc_index(rob_alloc_index),
      .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_val(cdb_val),
      .cdb_taken(cdb_taken), .cdb_target(cdb_target),
      .dc_rs1_depend(dc_rs1_depend), .rob_rs1_ready(rob_rs1_ready), .rob_rs1_val(rob_rs1_val),
      .dc_rs2_depend(dc_rs2_depend), .rob_rs2_ready(rob_rs2_ready), .rob_rs2_val(rob_rs2_val),
      .rob_to_reg_commit(rob_to_reg_commit), .rob_to_reg_rob_index(rob_to_reg_rob_index),
      .rob_to_reg_index(rob_to_reg_index), .rob_to_reg_val(rob_to_reg_val),
      .clr_out(clr_out), .clr_pc(clr_pc)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (rob_to_reg_commit === 1'b1) begin
         ccyc.push_back(cyc);
         if (sb.size() == 0) chk("spurious_commit", {31'b0, rob_to_reg_commit}, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("commit_tag", {28'b0, rob_to_reg_rob_index}, {28'b0, e.tag});
            chk("commit_rd", {27'b0, rob_to_reg_index}, {27'b0, e.rd});
            chk("commit_clr", {31'b0, clr_out}, {31'b0, e.clr});
            if (e.clr) chk("commit_clr_pc", clr_pc, e.pc);
            else chk("commit_val", rob_to_reg_val, e.val);
         end
      end else if (clr_out === 1'b1) chk("clr_without_commit", {31'b0, rob_to_reg_commit}, 32'd1);
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
   endtask

   task automatic issue(input logic [4:0] r, input logic br, input logic pr);
      issue_valid = 1'b1; issue_rd = r; issue_is_branch = br; issue_pred_taken = pr;
      tick();
      issue_valid = 1'b0; issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
   endtask

   task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
      cdb_valid = 1'b1; cdb_rob_index = t; cdb_val = v; cdb_taken = tk; cdb_target = tg;
      tick();
      cdb_valid = 1'b0;
      mark = cyc;
   endtask

   task automatic push(input logic [3:0] t, input logic [4:0] r, input logic [31:0] v,
                       input logic c, input logic [31:0] p);
      exp_t e;
      e.tag = t; e.rd = r; e.val = v; e.clr = c; e.pc = p;
      sb.push_back(e);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      // reset state
      do_reset();
      chk("rst_full", {31'b0, rob_full}, 0);
      chk("rst_alloc", {28'b0, rob_alloc_index}, 1);
      chk("rst_commit", {31'b0, rob_to_reg_commit}, 0);
      chk("rst_clr", {31'b0, clr_out}, 0);
      chk("rst_val", rob_to_reg_val, 0);

      // single issue / complete / commit
      issue(5'd5, 1'b0, 1'b0);
      chk("t1_alloc", {28'b0, rob_alloc_index}, 2);
      cdb(4'd1, 32'hDEADBEEF, 1'b0, 32'd0);
      push(4'd1, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0);
      drain("t1_drain");
      chk("t1_latency", ccyc[$], mark + 1);

      // fill to 15, reject issue while full even though a commit happens that cycle
      do_reset();
      for (int i = 1; i <= 15; i++) begin
         chk("t2_alloc_seq", {28'b0, rob_alloc_index}, i);
         issue(5'(i), 1'b0, 1'b0);
      end
      chk("t2_full", {31'b0, rob_full}, 1);
      chk("t2_alloc_wrap", {28'b0, rob_alloc_index}, 1);
      cdb(4'd1, 32'hA001, 1'b0, 32'd0);
      push(4'd1, 5'd1, 32'hA001, 1'b0, 32'd0);
      issue_valid = 1'b1; issue_rd = 5'd20;
      tick();
      chk("t2_rejected_alloc", {28'b0, rob_alloc_index}, 1);
      chk("t2_after_commit_full", {31'b0, rob_full}, 0);
      tick();
      issue_valid = 1'b0;
      chk("t2_accept_alloc", {28'b0, rob_alloc_index}, 2);
      chk("t2_refull", {31'b0, rob_full}, 1);
      for (int i = 2; i <= 15; i++) begin
         cdb(4'(i), 32'hA000 + i, 1'b0, 32'd0);
         push(4'(i), 5'(i), 32'hA000 + i, 1'b0, 32'd0);
      end
      cdb(4'd1, 32'hB001, 1'b0, 32'd0);
      push(4'd1, 5'd20, 32'hB001, 1'b0, 32'd0);
      drain("t2_drain");

      // out-of-order completion commits in order on consecutive cycles
      do_reset();
      issue(5'd7, 1'b0, 1'b0);
      issue(5'd8, 1'b0, 1'b0);
      issue(5'd9, 1'b0, 1'b0);
      cdb(4'd3, 32'h33, 1'b0, 32'd0);
      cdb(4'd2, 32'h22, 1'b0, 32'd0);
      cdb(4'd1, 32'h11, 1'b0, 32'd0);
      push(4'd1, 5'd7, 32'h11, 1'b0, 32'd0);
      push(4'd2, 5'd8, 32'h22, 1'b0, 32'd0);
      push(4'd3, 5'd9, 32'h33, 1'b0, 32'd0);
      drain("t3_drain");
      chk("t3_consecutive", ccyc[$] - ccyc[$-2], 2);

      // mispredicted branch flushes younger entries
      do_reset();
      issue(5'd4, 1'b0, 1'b0);
      issue(5'd0, 1'b1, 1'b0);
      issue(5'd6, 1'b0, 1'b0);
      cdb(4'd3, 32'h66, 1'b0, 32'd0);
      cdb(4'd2, 32'h0, 1'b1, 32'h100);
      cdb(4'd1, 32'h44, 1'b0, 32'd0);
      push(4'd1, 5'd4, 32'h44, 1'b0, 32'd0);
      push(4'd2, 5'd0, 32'h0, 1'b1, 32'h100);
      begin
         int n = 0;
         while (clr_out !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
      end
      chk("t4_clr_seen", {31'b0, clr_out}, 1);
      issue_valid = 1'b1; issue_rd = 5'd9;
      cdb_valid = 1'b1; cdb_rob_index = 4'd1; cdb_val = 32'h99;
      tick();
      issue_valid = 1'b0; cdb_valid = 1'b0;
      chk("t4_alloc_after_flush", {28'b0, rob_alloc_index}, 1);
      chk("t4_full_after_flush", {31'b0, rob_full}, 0);
      chk("t4_clr_one_cycle", {31'b0, clr_out}, 0);
      repeat (5) tick();
      chk("t4_drain", sb.size(), 0);

      // operand query with same-cycle CDB forwarding
      do_reset();
      for (int i = 1; i <= 4; i++) issue(5'(i + 10), 1'b0, 1'b0);
      cdb_valid = 1'b1; cdb_rob_index = 4'd4; cdb_val = 32'd7;
      dc_rs1_depend = 4'd4; dc_rs2_depend = 4'd0;
      #1;
      chk("t5_fwd_ready", {31'b0, rob_rs1_ready}, 1);
      chk("t5_fwd_val", rob_rs1_val, 7);
      chk("t5_dep0_ready", {31'b0, rob_rs2_ready}, 0);
      chk("t5_dep0_val", rob_rs2_val, 0);
      tick();
      cdb_valid = 1'b0;
      dc_rs2_depend = 4'd3;
      #1;
      chk("t5_stored_ready", {31'b0, rob_rs1_ready}, 1);
      chk("t5_stored_val", rob_rs1_val, 7);
      chk("t5_pending_ready", {31'b0, rob_rs2_ready}, 0);
      dc_rs1_depend = 4'd0; dc_rs2_depend = 4'd0;

      // rdy_in stall, then reset discards live entries
      do_reset();
      issue(5'd3, 1'b0, 1'b0);
      cdb(4'd1, 32'hABCD, 1'b0, 32'd0);
      rdy_in = 1'b0;
      repeat (3) tick();
      chk("t6_no_commit_stalled", {31'b0, rob_to_reg_commit}, 0);
      push(4'd1, 5'd3, 32'hABCD, 1'b0, 32'd0);
      rdy_in = 1'b1;
      mark = cyc;
      drain("t6_drain");
      chk("t6_resume_cycle", ccyc[$], mark + 1);
      issue(5'd1, 1'b0, 1'b0);
      issue(5'd2, 1'b0, 1'b0);
      issue(5'd3, 1'b0, 1'b0);
      cdb(4'd2, 32'h5555, 1'b0, 32'd0);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      dc_rs1_depend = 4'd2;
      #1;
      chk("t6_rst_commit", {31'b0, rob_to_reg_commit}, 0);
      chk("t6_rst_alloc", {28'b0, rob_alloc_index}, 1);
      chk("t6_rst_full", {31'b0, rob_full}, 0);
      chk("t6_rst_rd", {27'b0, rob_to_reg_index}, 0);
      chk("t6_rst_val", rob_to_reg_val, 0);
      chk("t6_rst_entry_gone", {31'b0, rob_rs1_ready}, 0);
      repeat (5) tick();
      chk("final_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
